fifo_burst_reader: RTL

Read-side companion for the synchronous FIFO. It drains the FIFO through its rd_en / out_valid port and absorbs the FIFO's one-cycle read latency with a 3-entry output buffer. It re-presents the data as a valid/ready stream framed into fixed-length bursts with a last marker. It sits between the FIFO and any downstream consumer that can apply backpressure.

---
 rtl/fifo_burst_reader_pkg.sv | 22 ++
 rtl/fifo_burst_reader_rd_buf3.sv | 79 +++++++
 rtl/fifo_burst_reader.sv | 110 +++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader_pkg
// Description : Shared defaults, buffer geometry and pointer helper for the
//               FIFO burst reader and its read buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_burst_reader_pkg;

  localparam int unsigned c_DATA_SIZE    = 64;
  localparam int unsigned c_BURST_LEN    = 16;
  localparam int unsigned c_BUF_DEPTH    = 3;
  localparam int unsigned c_BURST_CNT_W  = 16;
  localparam int unsigned c_PTR_W        = 2;

  // Advance a buffer pointer, wrapping modulo the buffer depth.
  function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(c_BUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_burst_reader_rd_buf3.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader_rd_buf3
// Description : 3-entry in-order buffer with occupancy count, push/pop and a
//               head-of-queue output. Reset clears the storage so the head
//               reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader_rd_buf3
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_SIZE = c_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [DATA_SIZE-1:0] i_push_data,
  input  logic                 i_pop,
  output logic [DATA_SIZE-1:0] o_head,
  output logic [c_PTR_W-1:0]   o_occ
);

  logic [DATA_SIZE-1:0] r_mem [c_BUF_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W-1:0]   r_occ;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign w_full    = (r_occ == c_PTR_W'(c_BUF_DEPTH));
  assign w_empty   = (r_occ == '0);
  // A push into a full buffer is only legal when a pop frees a slot the same
  // cycle; the upstream credit rule keeps this from ever being needed.
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && !w_empty;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(c_BUF_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + c_PTR_W'(1);
        2'b01:   r_occ <= r_occ - c_PTR_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Head-of-queue mux; the unused pointer code maps to zero.
  always_comb begin
    o_head = '0;
    case (r_rd_ptr)
      2'd0:    o_head = r_mem[0];
      2'd1:    o_head = r_mem[1];
      2'd2:    o_head = r_mem[2];
      default: o_head = '0;
    endcase
  end

  assign o_occ = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Drains a synchronous FIFO with one-cycle read latency into a
//               3-entry buffer and re-presents the data as a valid/ready
//               stream framed into fixed-length bursts with a last marker.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_SIZE = c_DATA_SIZE,
  parameter int unsigned BURST_LEN = c_BURST_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [DATA_SIZE-1:0]     fifo_data,
  input  logic                     fifo_valid,
  output logic [DATA_SIZE-1:0]     m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [c_BURST_CNT_W-1:0] burst_cnt,
  output logic                     err
);

  localparam logic [c_BURST_CNT_W-1:0] c_LAST_BEAT = c_BURST_CNT_W'(BURST_LEN - 1);

  logic                     r_inflight;
  logic                     r_err;
  logic [c_BURST_CNT_W-1:0] r_beat_cnt;
  logic [c_BURST_CNT_W-1:0] r_burst_cnt;

  logic [c_PTR_W-1:0]       w_occ;
  logic [c_PTR_W:0]         w_credit_used;
  logic                     w_rd_en;
  logic                     w_capture;
  logic                     w_spurious;
  logic                     w_valid;
  logic                     w_accept;
  logic                     w_at_last;

  // Credit: every outstanding read owns a buffer slot, so only registered
  // state feeds the read request and m_ready never reaches fifo_rd_en.
  assign w_credit_used = {1'b0, w_occ} + {{c_PTR_W{1'b0}}, r_inflight};
  assign w_rd_en       = !rst && !fifo_empty && (w_credit_used < (c_PTR_W + 1)'(c_BUF_DEPTH));
  assign fifo_rd_en    = w_rd_en;

  assign w_capture  = fifo_valid && r_inflight;
  assign w_spurious = fifo_valid && !r_inflight;

  assign w_valid   = (w_occ != '0);
  assign w_accept  = w_valid && m_ready;
  assign w_at_last = (r_beat_cnt == c_LAST_BEAT);

  fifo_burst_reader_rd_buf3 #(
    .DATA_SIZE (DATA_SIZE)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_capture),
    .i_push_data (fifo_data),
    .i_pop       (w_accept),
    .o_head      (m_data),
    .o_occ       (w_occ)
  );

  // Track whether a read response is due this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  // Sticky error on a response with no read outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_spurious) begin
      r_err <= 1'b1;
    end
  end

  // Burst framing: beat position and completed-burst count move only on
  // accepted beats; an open burst survives any FIFO-empty gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
    end else if (w_accept) begin
      if (w_at_last) begin
        r_beat_cnt  <= '0;
        r_burst_cnt <= r_burst_cnt + c_BURST_CNT_W'(1);
      end else begin
        r_beat_cnt  <= r_beat_cnt + c_BURST_CNT_W'(1);
      end
    end
  end

  assign m_valid   = w_valid;
  assign m_last    = w_valid && w_at_last;
  assign burst_cnt = r_burst_cnt;
  assign err       = r_err;

endmodule
`default_nettype wire
